ascon_aead_core: RTL and testbench



---
 rtl/ascon_pack.sv | 23 ++
 rtl/ascon_round.sv | 49 ++++
 rtl/ascon_aead_core.sv | 222 ++++++++++++++++++++++
 tb/tb_ascon_aead_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Ascon shared types: state array, IV, FSM encoding and round constants.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam logic [63:0] IV = 64'h80400C0600000000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_AD_WAIT = 3'd2,
        ST_AD_PERM = 3'd3,
        ST_PT_WAIT = 3'd4,
        ST_PT_PERM = 3'd5,
        ST_FINAL   = 3'd6,
        ST_DONE    = 3'd7
    } fsm_t;

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'd15 - r, r};
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant, S-box layer, diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state,
    input  logic [3:0] rnd,
    output type_state  next
);

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    type_state a, b, t, c, d;

    always_comb begin
        a = state;
        a[2] = state[2] ^ {56'd0, round_const(rnd)};

        b    = a;
        b[0] = a[0] ^ a[4];
        b[4] = a[4] ^ a[3];
        b[2] = a[2] ^ a[1];

        t = '0;
        c = '0;
        for (int i = 0; i < 5; i++) begin
            t[i] = ~b[i] & b[(i + 1) % 5];
        end
        for (int i = 0; i < 5; i++) begin
            c[i] = b[i] ^ t[(i + 1) % 5];
        end

        // Output stage of the S-box reads the pre-update words
        d    = c;
        d[1] = c[1] ^ c[0];
        d[0] = c[0] ^ c[4];
        d[3] = c[3] ^ c[2];
        d[2] = ~c[2];

        next    = '0;
        next[0] = d[0] ^ rotr(d[0], 19) ^ rotr(d[0], 28);
        next[1] = d[1] ^ rotr(d[1], 61) ^ rotr(d[1], 39);
        next[2] = d[2] ^ rotr(d[2], 1)  ^ rotr(d[2], 6);
        next[3] = d[3] ^ rotr(d[3], 10) ^ rotr(d[3], 17);
        next[4] = d[4] ^ rotr(d[4], 7)  ^ rotr(d[4], 41);
    end

endmodule

// File: rtl/ascon_aead_core.sv
// Ascon-128 AEAD core, one round per cycle, 64-bit block handshake.
// Decryption with tag check is built only when ASCON_DECRYPT_EN is defined.
module ascon_aead_core
    import ascon_pack::*;
#(
    parameter int AD_BLOCKS = 1,
    parameter int PT_BLOCKS = 4,
    parameter int ROUNDS_A  = 12,
    parameter int ROUNDS_B  = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] tag_i,
    input  logic [63:0]  data_i,
    input  logic         data_valid_i,
    output logic         data_ready_o,
    output logic [63:0]  cipher_o,
    output logic         cipher_valid_o,
    output logic         busy_o,
    output logic         end_o,
    output logic [127:0] tag_o,
    output logic         tag_ok_o
);

    localparam int BMAX = (AD_BLOCKS > PT_BLOCKS) ? AD_BLOCKS : PT_BLOCKS;
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [3:0] LAST_A = 4'(ROUNDS_A - 1);
    localparam logic [3:0] LAST_B = 4'(ROUNDS_B - 1);
    localparam logic [3:0] OFS_B  = 4'(ROUNDS_A - ROUNDS_B);

    fsm_t            st, st_n;
    type_state       s, s_n, rnd_out;
    logic [127:0]    key_q, key_n;
    logic [3:0]      rcnt, rcnt_n, rnd;
    logic [BW-1:0]   ad_cnt, ad_n, pt_cnt, pt_n;
    logic [63:0]     co_n;
    logic            cv_n, end_n, ok_n;
    logic [127:0]    tag_n, tag_calc;
    logic            mode_q;

`ifdef ASCON_DECRYPT_EN
    logic [127:0] tag_exp;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mode_q  <= 1'b0;
            tag_exp <= '0;
        end else if (st == ST_IDLE && start_i) begin
            mode_q  <= mode_i;
            tag_exp <= tag_i;
        end
    end
`else
    logic unused_dec;

    assign mode_q     = 1'b0;
    assign unused_dec = ^{mode_i, tag_i};
`endif

    assign rnd = (st == ST_INIT || st == ST_FINAL) ? rcnt : rcnt + OFS_B;

    ascon_round u_round (
        .state (s),
        .rnd   (rnd),
        .next  (rnd_out)
    );

    assign tag_calc     = {rnd_out[3], rnd_out[4]} ^ key_q;
    assign data_ready_o = (st == ST_AD_WAIT) || (st == ST_PT_WAIT);
    assign busy_o       = (st != ST_IDLE);

    always_comb begin
        st_n   = st;
        s_n    = s;
        key_n  = key_q;
        rcnt_n = rcnt;
        ad_n   = ad_cnt;
        pt_n   = pt_cnt;
        co_n   = cipher_o;
        cv_n   = 1'b0;
        end_n  = 1'b0;
        tag_n  = tag_o;
        ok_n   = tag_ok_o;

        unique case (st)
            ST_IDLE: begin
                if (start_i) begin
                    st_n   = ST_INIT;
                    key_n  = key_i;
                    s_n[0] = IV;
                    s_n[1] = key_i[127:64];
                    s_n[2] = key_i[63:0];
                    s_n[3] = nonce_i[127:64];
                    s_n[4] = nonce_i[63:0];
                    rcnt_n = '0;
                    ad_n   = '0;
                    pt_n   = '0;
                    tag_n  = '0;
                    ok_n   = 1'b0;
                end
            end
            ST_INIT: begin
                s_n    = rnd_out;
                rcnt_n = rcnt + 4'd1;
                if (rcnt == LAST_A) begin
                    rcnt_n = '0;
                    s_n[3] = rnd_out[3] ^ key_q[127:64];
                    s_n[4] = rnd_out[4] ^ key_q[63:0];
                    if (AD_BLOCKS > 0) begin
                        st_n = ST_AD_WAIT;
                    end else begin
                        s_n[4] = rnd_out[4] ^ key_q[63:0] ^ 64'd1;
                        st_n   = ST_PT_WAIT;
                    end
                end
            end
            ST_AD_WAIT: begin
                if (data_valid_i) begin
                    s_n[0] = s[0] ^ data_i;
                    ad_n   = ad_cnt + BW'(1);
                    rcnt_n = '0;
                    st_n   = ST_AD_PERM;
                end
            end
            ST_AD_PERM: begin
                s_n    = rnd_out;
                rcnt_n = rcnt + 4'd1;
                if (rcnt == LAST_B) begin
                    rcnt_n = '0;
                    st_n   = ST_AD_WAIT;
                    // Domain separation once the last AD block is absorbed
                    if (ad_cnt == BW'(AD_BLOCKS)) begin
                        s_n[4] = rnd_out[4] ^ 64'd1;
                        st_n   = ST_PT_WAIT;
                    end
                end
            end
            ST_PT_WAIT: begin
                if (data_valid_i) begin
                    co_n   = s[0] ^ data_i;
                    cv_n   = 1'b1;
                    s_n[0] = mode_q ? data_i : s[0] ^ data_i;
                    pt_n   = pt_cnt + BW'(1);
                    rcnt_n = '0;
                    st_n   = ST_PT_PERM;
                    if (pt_cnt == BW'(PT_BLOCKS - 1)) begin
                        s_n[1] = s[1] ^ key_q[127:64];
                        s_n[2] = s[2] ^ key_q[63:0];
                        st_n   = ST_FINAL;
                    end
                end
            end
            ST_PT_PERM: begin
                s_n    = rnd_out;
                rcnt_n = rcnt + 4'd1;
                if (rcnt == LAST_B) begin
                    rcnt_n = '0;
                    st_n   = ST_PT_WAIT;
                end
            end
            ST_FINAL: begin
                s_n    = rnd_out;
                rcnt_n = rcnt + 4'd1;
                if (rcnt == LAST_A) begin
                    rcnt_n = '0;
                    tag_n  = tag_calc;
                    end_n  = 1'b1;
                    st_n   = ST_DONE;
`ifdef ASCON_DECRYPT_EN
                    ok_n   = mode_q && (tag_calc == tag_exp);
`else
                    ok_n   = 1'b0;
`endif
                end
            end
            ST_DONE: begin
                st_n = ST_IDLE;
            end
            default: begin
                st_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            st             <= ST_IDLE;
            s              <= '0;
            key_q          <= '0;
            rcnt           <= '0;
            ad_cnt         <= '0;
            pt_cnt         <= '0;
            cipher_o       <= '0;
            cipher_valid_o <= 1'b0;
            end_o          <= 1'b0;
            tag_o          <= '0;
            tag_ok_o       <= 1'b0;
        end else begin
            st             <= st_n;
            s              <= s_n;
            key_q          <= key_n;
            rcnt           <= rcnt_n;
            ad_cnt         <= ad_n;
            pt_cnt         <= pt_n;
            cipher_o       <= co_n;
            cipher_valid_o <= cv_n;
            end_o          <= end_n;
            tag_o          <= tag_n;
            tag_ok_o       <= tag_ok_n_sel(ok_n);
        end
    end

    function automatic logic tag_ok_n_sel(input logic v);
        return v;
    endfunction

endmodule

// File: tb/tb_ascon_aead_core.sv
// Randomised bench for ascon_aead_core against a table-driven Ascon model.
// Decrypt checks are compiled when ASCON_DECRYPT_EN is defined.
module tb_ascon_aead_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ASCON_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic         rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic         mode = 1'b0, valid = 1'b0, sel = 1'b0;
    logic [127:0] key = '0, nonce = '0, tagx = '0;
    logic [63:0]  data = '0;

    logic         rdy0, rdy1, cv0, cv1, busy0, busy1;
    logic         end0, end1, ok0, ok1;
    logic [63:0]  co0, co1;
    logic [127:0] tg0, tg1;

    int checks = 0;
    int fails  = 0;

    logic [63:0]  ad_blk [8];
    logic [63:0]  in_blk [8];
    logic [63:0]  exp_out [8];
    logic [63:0]  got_out [8];
    logic [63:0]  ms [5];
    logic [127:0] exp_tag, got_tag;
    logic         exp_ok, got_ok;
    logic [63:0]  pt_save [8];
    logic [63:0]  ct_save [8];
    logic [127:0] tag_save;

    ascon_aead_core dut0 (
        .clock_i(clk), .reset_i(rst), .start_i(start0), .mode_i(mode),
        .key_i(key), .nonce_i(nonce), .tag_i(tagx), .data_i(data),
        .data_valid_i(valid), .data_ready_o(rdy0), .cipher_o(co0),
        .cipher_valid_o(cv0), .busy_o(busy0), .end_o(end0),
        .tag_o(tg0), .tag_ok_o(ok0)
    );

    ascon_aead_core #(.AD_BLOCKS(0), .PT_BLOCKS(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(start1), .mode_i(mode),
        .key_i(key), .nonce_i(nonce), .tag_i(tagx), .data_i(data),
        .data_valid_i(valid), .data_ready_o(rdy1), .cipher_o(co1),
        .cipher_valid_o(cv1), .busy_o(busy1), .end_o(end1),
        .tag_o(tg1), .tag_ok_o(ok1)
    );

    wire          m_rdy  = sel ? rdy1  : rdy0;
    wire          m_cv   = sel ? cv1   : cv0;
    wire          m_busy = sel ? busy1 : busy0;
    wire          m_end  = sel ? end1  : end0;
    wire          m_ok   = sel ? ok1   : ok0;
    wire [63:0]   m_co   = sel ? co1   : co0;
    wire [127:0]  m_tag  = sel ? tg1   : tg0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic perm(input int first, input int n);
        logic [63:0] y [5];
        logic [4:0]  col, o;
        for (int r = first; r < first + n; r++) begin
            ms[2] ^= 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                col = {ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]};
                o   = SBOX[col];
                for (int w = 0; w < 5; w++) y[w][b] = o[4 - w];
            end
            ms[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
            ms[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
            ms[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
            ms[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
            ms[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        end
    endtask

    task automatic model(input int nad, input int npt, input bit dec);
        ms[0] = 64'h80400C0600000000;
        ms[1] = key[127:64];
        ms[2] = key[63:0];
        ms[3] = nonce[127:64];
        ms[4] = nonce[63:0];
        perm(0, 12);
        ms[3] ^= key[127:64];
        ms[4] ^= key[63:0];
        for (int i = 0; i < nad; i++) begin
            ms[0] ^= ad_blk[i];
            perm(6, 6);
        end
        ms[4] ^= 64'd1;
        for (int i = 0; i < npt; i++) begin
            exp_out[i] = ms[0] ^ in_blk[i];
            ms[0] = dec ? in_blk[i] : exp_out[i];
            if (i < npt - 1) perm(6, 6);
        end
        ms[1] ^= key[127:64];
        ms[2] ^= key[63:0];
        perm(0, 12);
        exp_tag = {ms[3], ms[4]} ^ key;
        exp_ok  = dec && (exp_tag == tagx);
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 128'(m_busy), 128'd0);
        chk({nm, "_rdy"},  128'(m_rdy),  128'd0);
        chk({nm, "_cv"},   128'(m_cv),   128'd0);
        chk({nm, "_end"},  128'(m_end),  128'd0);
        chk({nm, "_co"},   128'(m_co),   128'd0);
        chk({nm, "_tag"},  m_tag,        128'd0);
        chk({nm, "_ok"},   128'(m_ok),   128'd0);
    endtask

    task automatic do_run(input string nm, input int nad, input int npt,
                          input bit dec, input int maxstall, input bit hold,
                          input int abort_at);
        int cyc = 0, blk = 0, oc = 0, stalls = 0, ends = 0, lat = -1, sl;
        bit done = 0, acc;
        model(nad, npt, dec && DEC_EN);
        sl = $urandom_range(0, maxstall);
        @(negedge clk);
        mode = dec;
        set_start(1'b1);
        valid = 1'b0;
        @(posedge clk);
        while (!done && cyc < 600) begin
            @(negedge clk);
            if (!hold) set_start(1'b0);
            if (cyc == abort_at) begin
                valid = 1'b0;
                set_start(1'b0);
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk_zero({nm, "_rst"});
                rst = 1'b0;
                repeat (60) begin
                    @(negedge clk);
                    chk({nm, "_noend"}, 128'(m_end), 128'd0);
                end
                return;
            end
            if (m_cv) begin
                if (oc < 8) got_out[oc] = m_co;
                oc++;
            end
            if (m_end) begin
                ends++;
                lat     = cyc;
                got_tag = m_tag;
                got_ok  = m_ok;
                valid   = 1'b0;
                if (hold) begin
                    set_start(1'b0);
                    @(posedge clk);
                    @(negedge clk);
                    chk({nm, "_idle"}, 128'(m_busy), 128'd0);
                    chk({nm, "_ends"}, 128'(ends), 128'd1);
                end
                done = 1;
            end else begin
                acc = 1'b0;
                if (m_rdy && sl > 0) begin
                    valid = 1'b0;
                    sl--;
                    stalls++;
                end else if (m_rdy) begin
                    valid = 1'b1;
                    data  = (blk < nad) ? ad_blk[blk] : in_blk[blk - nad];
                    acc   = 1'b1;
                end else begin
                    valid = 1'b0;
                    data  = 64'(~$urandom);
                end
                @(posedge clk);
                cyc++;
                if (acc) begin
                    blk++;
                    sl = $urandom_range(0, maxstall);
                end
            end
        end
        valid = 1'b0;
        chk({nm, "_timeout"}, 128'(done), 128'd1);
        chk({nm, "_nout"}, 128'(oc), 128'(npt));
        for (int i = 0; i < npt && i < 8; i++)
            chk($sformatf("%s_out%0d", nm, i), 128'(got_out[i]), 128'(exp_out[i]));
        chk({nm, "_tag"}, got_tag, exp_tag);
        chk({nm, "_ok"}, 128'(got_ok), 128'(exp_ok));
        chk({nm, "_lat"}, 128'(lat),
            128'(2 * 12 + 7 * (nad + npt - 1) + 1 + stalls));
    endtask

    task automatic rand_vec(input int nad, input int npt);
        key   = {$urandom, $urandom, $urandom, $urandom};
        nonce = {$urandom, $urandom, $urandom, $urandom};
        tagx  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < nad; i++) ad_blk[i] = {$urandom, $urandom};
        for (int i = 0; i < npt; i++) in_blk[i] = {$urandom, $urandom};
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset0");
        sel = 1'b1;
        #0 chk_zero("reset1");
        sel = 1'b0;
        rst = 1'b0;

        key   = 128'h000102030405060708090A0B0C0D0E0F;
        nonce = 128'h000102030405060708090A0B0C0D0E0F;
        ad_blk[0] = 64'h0001020304050607;
        for (int i = 0; i < 4; i++) begin
            in_blk[i]  = 64'h0001020304050607 + 64'(i) * 64'h0808080808080808;
            pt_save[i] = in_blk[i];
        end
        do_run("enc", 1, 4, 1'b0, 0, 1'b0, -1);
        for (int i = 0; i < 4; i++) ct_save[i] = got_out[i];
        tag_save = got_tag;

        do_run("stall", 1, 4, 1'b0, 5, 1'b0, -1);

        for (int i = 0; i < 4; i++) in_blk[i] = ct_save[i];
        tagx = tag_save;
        do_run("dec", 1, 4, 1'b1, 2, 1'b0, -1);
        if (DEC_EN) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("dec_pt%0d", i), 128'(got_out[i]), 128'(pt_save[i]));
            chk("dec_tagok", 128'(got_ok), 128'd1);
        end
        tagx = tag_save ^ 128'd1;
        do_run("decbad", 1, 4, 1'b1, 0, 1'b0, -1);
        chk("decbad_tagok", 128'(got_ok), 128'd0);

        rand_vec(1, 4);
        do_run("abort", 1, 4, 1'b0, 0, 1'b0, 45);
        rand_vec(1, 4);
        do_run("fresh", 1, 4, 1'b0, 0, 1'b0, -1);

        rand_vec(1, 4);
        do_run("hold", 1, 4, 1'b0, 1, 1'b1, -1);

        for (int k = 0; k < 4; k++) begin
            rand_vec(1, 4);
            do_run($sformatf("rnd%0d", k), 1, 4, 1'($urandom_range(0, 1)),
                   3, 1'b0, -1);
        end

        sel = 1'b1;
        rand_vec(0, 1);
        do_run("small", 0, 1, 1'b0, 0, 1'b0, -1);
        for (int k = 0; k < 2; k++) begin
            rand_vec(0, 1);
            do_run($sformatf("small%0d", k), 0, 1, 1'b0, 4, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
